// File: rtl/writeback_multi.sv
// writeback_multi: multi-lane in-order writeback and retirement stage.
//
// Accepts a bundle of up to LANES instructions (lane 0 oldest) and retires the
// contiguous valid prefix. The prefix stops at the first exception, or after the
// first serializing lane (csr_write, mret or wfi). A pending interrupt at
// acceptance traps before lane 0. A retiring wfi puts the stage to sleep. While
// asleep it accepts no bundles, and it wakes through an interrupt trap to the
// captured next_pc. Every output except ready_out is registered.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   lane_valid_in          per-lane valid (contiguous from lane 0)
//   ready_out              stage can accept a bundle (RUN state)
//   pc_in .. load_data_in  per-lane PC and data sources, lane i at [i*XLEN +: XLEN]
//   write_select_in        per-lane rd_data source: 0 ALU, 1 CSR, 2 LOAD, 3 next_pc
//   rd_address_in          per-lane destination register
//   csr_address_in         per-lane CSR address
//   ecause_in              per-lane exception cause
//   csr_write_in, mret_in, wfi_in, exception_in   per-lane flags
//   sip, tip, eip          pending interrupts from the csr block
//   rd_address, rd_data    regfile write ports (rd_address 0 means no write)
//   csr_write, csr_address, csr_data   CSR write port
//   traped, mret, ecp, ecause, interupt  trap / return signalling
//   retired, instret       lanes retired this cycle, 64-bit retirement counter
module writeback_multi #(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES-1:0]           lane_valid_in,
  output logic                       ready_out,
  input  logic [LANES*XLEN-1:0]      pc_in,
  input  logic [LANES*XLEN-1:0]      next_pc_in,
  input  logic [LANES*XLEN-1:0]      alu_data_in,
  input  logic [LANES*XLEN-1:0]      csr_data_in,
  input  logic [LANES*XLEN-1:0]      load_data_in,
  input  logic [2*LANES-1:0]         write_select_in,
  input  logic [5*LANES-1:0]         rd_address_in,
  input  logic [12*LANES-1:0]        csr_address_in,
  input  logic [4*LANES-1:0]         ecause_in,
  input  logic [LANES-1:0]           csr_write_in,
  input  logic [LANES-1:0]           mret_in,
  input  logic [LANES-1:0]           wfi_in,
  input  logic [LANES-1:0]           exception_in,
  input  logic                       sip,
  input  logic                       tip,
  input  logic                       eip,
  output logic [5*LANES-1:0]         rd_address,
  output logic [LANES*XLEN-1:0]      rd_data,
  output logic                       csr_write,
  output logic [11:0]                csr_address,
  output logic [XLEN-1:0]            csr_data,
  output logic                       traped,
  output logic                       mret,
  output logic [XLEN-1:0]            ecp,
  output logic [3:0]                 ecause,
  output logic                       interupt,
  output logic [$clog2(LANES+1)-1:0] retired,
  output logic [63:0]                instret
);

  localparam int unsigned RetW = $clog2(LANES + 1);

  typedef enum logic [0:0] {StRun, StSleep} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     wfi_pc_q, wfi_pc_d;
  logic [5*LANES-1:0]  rd_addr_q, rd_addr_d;
  logic [LANES*XLEN-1:0] rd_data_q, rd_data_d;
  logic                csr_we_q, csr_we_d;
  logic [11:0]         csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]     csr_data_q, csr_data_d;
  logic                trap_q, trap_d;
  logic                mret_q, mret_d;
  logic [XLEN-1:0]     ecp_q, ecp_d;
  logic [3:0]          ecause_q, ecause_d;
  logic                irq_q, irq_d;
  logic [RetW-1:0]     ret_q, ret_d;
  logic [63:0]         instret_q;

  logic       irq_pending;
  logic [3:0] irq_cause;
  logic       accept;
  logic       lane_ok;  // lane is part of the contiguous valid prefix
  logic       stop;     // a trap or serializing lane ended retirement

  assign ready_out   = (state_q == StRun);
  assign accept      = ready_out & lane_valid_in[0];
  assign irq_pending = sip | tip | eip;
  assign irq_cause   = eip ? 4'd11 : (tip ? 4'd7 : 4'd3);

  always_comb begin
    state_d    = state_q;
    wfi_pc_d   = wfi_pc_q;
    rd_addr_d  = '0;
    rd_data_d  = '0;
    csr_we_d   = 1'b0;
    csr_addr_d = '0;
    csr_data_d = '0;
    trap_d     = 1'b0;
    mret_d     = 1'b0;
    ecp_d      = '0;
    ecause_d   = '0;
    irq_d      = 1'b0;
    ret_d      = '0;
    lane_ok    = 1'b1;
    stop       = 1'b0;

    for (int i = 0; i < LANES; i++) begin
      unique case (write_select_in[i*2 +: 2])
        2'd0:    rd_data_d[i*XLEN +: XLEN] = alu_data_in[i*XLEN +: XLEN];
        2'd1:    rd_data_d[i*XLEN +: XLEN] = csr_data_in[i*XLEN +: XLEN];
        2'd2:    rd_data_d[i*XLEN +: XLEN] = load_data_in[i*XLEN +: XLEN];
        default: rd_data_d[i*XLEN +: XLEN] = next_pc_in[i*XLEN +: XLEN];
      endcase
    end

    if (state_q == StSleep) begin
      if (irq_pending) begin
        trap_d   = 1'b1;
        ecp_d    = wfi_pc_q;
        ecause_d = irq_cause;
        irq_d    = 1'b1;
        state_d  = StRun;
      end
    end else if (accept) begin
      if (irq_pending) begin
        // Interrupt is taken before the oldest lane; nothing retires.
        trap_d   = 1'b1;
        ecp_d    = pc_in[XLEN-1:0];
        ecause_d = irq_cause;
        irq_d    = 1'b1;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          lane_ok = lane_ok & lane_valid_in[i];
          if (lane_ok && !stop) begin
            if (exception_in[i]) begin
              trap_d   = 1'b1;
              ecp_d    = pc_in[i*XLEN +: XLEN];
              ecause_d = ecause_in[i*4 +: 4];
              stop     = 1'b1;
            end else begin
              rd_addr_d[i*5 +: 5] = rd_address_in[i*5 +: 5];
              ret_d = ret_d + RetW'(1);
              if (csr_write_in[i]) begin
                csr_we_d   = 1'b1;
                csr_addr_d = csr_address_in[i*12 +: 12];
                csr_data_d = alu_data_in[i*XLEN +: XLEN];
              end
              if (mret_in[i]) mret_d = 1'b1;
              if (wfi_in[i]) begin
                state_d  = StSleep;
                wfi_pc_d = next_pc_in[i*XLEN +: XLEN];
              end
              if (csr_write_in[i] || mret_in[i] || wfi_in[i]) stop = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      wfi_pc_q   <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      csr_we_q   <= 1'b0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      trap_q     <= 1'b0;
      mret_q     <= 1'b0;
      ecp_q      <= '0;
      ecause_q   <= '0;
      irq_q      <= 1'b0;
      ret_q      <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wfi_pc_q   <= wfi_pc_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      csr_we_q   <= csr_we_d;
      csr_addr_q <= csr_addr_d;
      csr_data_q <= csr_data_d;
      trap_q     <= trap_d;
      mret_q     <= mret_d;
      ecp_q      <= ecp_d;
      ecause_q   <= ecause_d;
      irq_q      <= irq_d;
      ret_q      <= ret_d;
      // Counter moves on the same edge that publishes retired.
      instret_q  <= instret_q + 64'(ret_d);
    end
  end

  assign rd_address  = rd_addr_q;
  assign rd_data     = rd_data_q;
  assign csr_write   = csr_we_q;
  assign csr_address = csr_addr_q;
  assign csr_data    = csr_data_q;
  assign traped      = trap_q;
  assign mret        = mret_q;
  assign ecp         = ecp_q;
  assign ecause      = ecause_q;
  assign interupt    = irq_q;
  assign retired     = ret_q;
  assign instret     = instret_q;

endmodule
